// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: operation encoding and parameter helpers.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_BRANCH,
      PC_CALL,
      PC_RET,
      PC_LOAD
   } pc_op_t;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with a next-write pointer and a saturating count.
// When full, a push overwrites the oldest entry and raises ovf_set for that cycle.
module ras_stack #(
   parameter int DATA_WIDTH = 32,
   parameter int RAS_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           push,
   input  logic                           pop,
   input  logic [DATA_WIDTH-1:0]          push_data,
   output logic [DATA_WIDTH-1:0]          top_data,
   output logic [$clog2(RAS_DEPTH+1)-1:0] count,
   output logic                           ovf_set
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int PW = $clog2(RAS_DEPTH);

   logic [DATA_WIDTH-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         top_idx;
   logic [PW-1:0]         wr_ptr_inc;
   logic                  full;

   // wr_ptr names the next free slot; the newest entry sits one below it (mod depth)
   assign top_idx    = (wr_ptr == '0) ? PW'(RAS_DEPTH - 1) : wr_ptr - PW'(1);
   assign wr_ptr_inc = (wr_ptr == PW'(RAS_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
   assign full       = (count == CW'(RAS_DEPTH));
   assign top_data   = mem[top_idx];
   assign ovf_set    = push && full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr_inc;
         if (!full)
            count <= count + CW'(1);
      end else if (pop && (count != '0)) begin
         wr_ptr <= top_idx;
         count  <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/program_counter_stack.sv
// Fetch-stage program counter with step, branch, load, stall and call/return via a RAS.
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module program_counter_stack
   import pc_pkg::*;
#(
   parameter int                  DATA_WIDTH   = 32,
   parameter int                  STEP         = 4,
   parameter int                  RAS_DEPTH    = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           stall,
   input  logic                           increment,
   input  logic                           load,
   input  logic                           branch,
   input  logic signed [DATA_WIDTH-1:0]   branch_offset,
   input  logic                           call,
   input  logic                           ret,
   input  logic [DATA_WIDTH-1:0]          pc_in,
   output logic [DATA_WIDTH-1:0]          pc_out,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_empty,
   output logic                           ras_full,
   output logic                           ras_ovf,
   output logic                           ret_err,
   output logic                           align_fault
);

   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

   if (!is_pow2(STEP)) begin : g_step_chk
      $error("program_counter_stack: STEP must be a power of two");
   end
   if (RAS_DEPTH < 2) begin : g_depth_chk
      $error("program_counter_stack: RAS_DEPTH must be at least 2");
   end

   pc_op_t                op;
   logic [DATA_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] pc_next;
   logic [DATA_WIDTH-1:0] top_data;
   logic                  misaligned;
   logic                  ras_push;
   logic                  ras_pop;
   logic                  ovf_set;

   // Stall outranks everything and maps to HOLD, so it suppresses all side effects
   always_comb begin
      op = PC_HOLD;
      if (stall)          op = PC_HOLD;
      else if (load)      op = PC_LOAD;
      else if (ret)       op = PC_RET;
      else if (call)      op = PC_CALL;
      else if (branch)    op = PC_BRANCH;
      else if (increment) op = PC_INC;
   end

   assign target = (op == PC_BRANCH) ? pc_out + $unsigned(branch_offset) : pc_in;

`ifdef PC_ALIGN_CHECK_EN
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(STEP - 1);
   assign misaligned = ((op == PC_LOAD) || (op == PC_CALL) || (op == PC_BRANCH)) &&
                       ((target & ALIGN_MASK) != '0);
`else
   assign misaligned = 1'b0;
`endif

   assign ras_push = (op == PC_CALL) && !misaligned;
   assign ras_pop  = (op == PC_RET) && (ras_count != '0);

   always_comb begin
      pc_next = pc_out;
      unique case (op)
         PC_INC:                       pc_next = pc_out + STEP_V;
         PC_LOAD, PC_CALL, PC_BRANCH:  if (!misaligned) pc_next = target;
         PC_RET:                       if (ras_count != '0) pc_next = top_data;
         default:                      pc_next = pc_out;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_out      <= RESET_VECTOR;
         ras_ovf     <= 1'b0;
         ret_err     <= 1'b0;
         align_fault <= 1'b0;
      end else begin
         pc_out      <= pc_next;
         ras_ovf     <= ras_ovf | ovf_set;
         ret_err     <= (op == PC_RET) && (ras_count == '0);
         align_fault <= misaligned;
      end
   end

   assign ras_empty = (ras_count == '0);
   assign ras_full  = (ras_count == CW'(RAS_DEPTH));

   ras_stack #(
      .DATA_WIDTH (DATA_WIDTH),
      .RAS_DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_out + STEP_V),
      .top_data  (top_data),
      .count     (ras_count),
      .ovf_set   (ovf_set)
   );

endmodule
